// File: rtl/odometer_beat_counter_pkg.sv
// Shared types and helpers for the ring-oscillator odometer measurement stage.
// Holds the measurement FSM encoding, default sizing and the saturating increment.
package odometer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2,
      FIN  = 2'd3
   } odo_state_e;

   localparam int CNT_W_DEF    = 16;
   localparam int NB_W_DEF     = 4;
   localparam int DEGLITCH_DEF = 2;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] maxv;
      if (width >= 32'd32) begin
         maxv = 32'hFFFF_FFFF;
      end else begin
         maxv = (32'd1 << width) - 32'd1;
      end
      if (val >= maxv) begin
         return maxv;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/beat_deglitch.sv
// Synchronizes the raw STRESS ROSC beat into the REF clock domain, filters short
// glitches and flags each rising edge of the filtered beat.
module beat_deglitch #(
   parameter int DEGLITCH = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic STRESS_IN,
   output logic FILT,
   output logic EDGE
);

   logic                s0_r;
   logic                s1_r;
   logic [DEGLITCH-1:0] hist_r;
   logic [DEGLITCH:0]   hist_ext_s;
   logic                filt_r;
   logic                filt_d_r;
   logic                stable_s;

   assign hist_ext_s = {hist_r, s1_r};
   assign stable_s   = (hist_r == {DEGLITCH{s1_r}});

   // Two-flop synchronizer, sample history and filtered level.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s0_r     <= 1'b0;
         s1_r     <= 1'b0;
         hist_r   <= '0;
         filt_r   <= 1'b0;
         filt_d_r <= 1'b0;
      end else begin
         s0_r     <= STRESS_IN;
         s1_r     <= s0_r;
         hist_r   <= hist_ext_s[DEGLITCH-1:0];
         filt_d_r <= filt_r;
         if (stable_s && (s1_r != filt_r)) begin
            filt_r <= s1_r;
         end else begin
            filt_r <= filt_r;
         end
      end
   end

   assign FILT = filt_r;
   assign EDGE = filt_r & ~filt_d_r;

endmodule

// File: rtl/odometer_beat_counter.sv
// Counts REF clock cycles over a programmable number of filtered STRESS beat periods;
// the saturating result is the odometer degradation readout.
module odometer_beat_counter
   import odometer_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int NB_W     = NB_W_DEF,
   parameter int DEGLITCH = DEGLITCH_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [NB_W-1:0]  NUM_BEATS,
   input  logic             STRESS_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] COUNT,
   output logic             OVF
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [NB_W-1:0]  NB_ONE  = NB_W'(1'b1);

   odo_state_e       state_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] count_r;
   logic             ovf_out_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ovf_r;
   logic [NB_W-1:0]  nb_r;
   logic [NB_W-1:0]  rem_r;
   logic [NB_W-1:0]  nb_start_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             at_max_s;
   logic             filt_s;
   logic             edge_s;
   logic             unused_filt_s;

   beat_deglitch #(
      .DEGLITCH (DEGLITCH)
   ) u_deglitch (
      .CLK       (CLK),
      .RST       (RST),
      .STRESS_IN (STRESS_IN),
      .FILT      (filt_s),
      .EDGE      (edge_s)
   );

   assign unused_filt_s = filt_s;
   assign cnt_inc_s     = CNT_W'(sat_inc(32'(cnt_r), CNT_W));
   assign at_max_s      = (cnt_r == CNT_MAX);

   // A zero beat request still measures one full period.
   always_comb begin
      nb_start_s = NUM_BEATS;
      if (NUM_BEATS == '0) begin
         nb_start_s = NB_ONE;
      end else begin
         nb_start_s = NUM_BEATS;
      end
   end

   // Measurement FSM, cycle counter and registered result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         count_r   <= '0;
         ovf_out_r <= 1'b0;
         cnt_r     <= '0;
         ovf_r     <= 1'b0;
         nb_r      <= '0;
         rem_r     <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (START) begin
                  nb_r    <= nb_start_s;
                  busy_r  <= 1'b1;
                  state_r <= ARM;
               end
            end
            // The arming edge only opens the window; it is not a counted period.
            ARM: begin
               if (edge_s) begin
                  cnt_r   <= '0;
                  ovf_r   <= 1'b0;
                  rem_r   <= nb_r;
                  state_r <= MEAS;
               end
            end
            MEAS: begin
               cnt_r <= cnt_inc_s;
               if (at_max_s) begin
                  ovf_r <= 1'b1;
               end
               if (edge_s) begin
                  rem_r <= rem_r - NB_ONE;
                  if (rem_r == NB_ONE) begin
                     count_r   <= cnt_inc_s;
                     ovf_out_r <= ovf_r | at_max_s;
                     done_r    <= 1'b1;
                     state_r   <= FIN;
                  end
               end
            end
            FIN: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign BUSY  = busy_r;
   assign DONE  = done_r;
   assign COUNT = count_r;
   assign OVF   = ovf_out_r;

endmodule

// File: tb/tb_odometer_beat_counter.sv
// Self-checking bench for odometer_beat_counter: square-wave beats, randomized periods,
// beat counts and start phases, checked against N*P with saturation.
module tb_odometer_beat_counter;

   localparam int CNT_W = 8;
   localparam int NB_W  = 4;
   localparam int MAXC  = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [NB_W-1:0]  num_beats = '0;
   logic             stress_in = 1'b0;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             ovf;

   int total = 0;
   int bad   = 0;

   int wave_period = 20;
   int ph = 0;
   bit wave_on = 1'b1;
   bit glitch_en = 1'b0;

   odometer_beat_counter #(
      .CNT_W    (CNT_W),
      .NB_W     (NB_W),
      .DEGLITCH (2)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .START     (start),
      .NUM_BEATS (num_beats),
      .STRESS_IN (stress_in),
      .BUSY      (busy),
      .DONE      (done),
      .COUNT     (count),
      .OVF       (ovf)
   );

   always #5 clk = ~clk;

   // Beat source: high for the first half period, optional one-cycle glitch in the low half.
   initial begin
      forever begin
         @(negedge clk);
         if (wave_on) begin
            stress_in = (ph < wave_period / 2) ||
                        (glitch_en && (ph == wave_period / 2 + wave_period / 4));
            ph = ph + 1;
            if (ph >= wave_period) ph = 0;
         end else begin
            stress_in = 1'b0;
         end
      end
   end

   task automatic set_wave(input int p, input bit glitch);
      wave_period = p;
      ph = 0;
      glitch_en = glitch;
      wave_on = 1'b1;
      repeat (2 * p) @(negedge clk);
   endtask

   // One measurement; restart_at>0 pulses START again (NUM_BEATS=1) that many cycles in.
   task automatic run_meas(input int n, input string name, input int restart_at);
      int exp_n, prod, exp_cnt, bound, extra;
      bit exp_ovf, seen;
      logic [CNT_W-1:0] got_cnt;
      logic got_ovf;
      exp_n   = (n == 0) ? 1 : n;
      prod    = exp_n * wave_period;
      exp_ovf = (prod > MAXC);
      exp_cnt = exp_ovf ? MAXC : prod;
      repeat ($urandom_range(0, wave_period - 1)) @(negedge clk);
      start = 1'b1;
      num_beats = NB_W'(n);
      @(negedge clk);
      start = 1'b0;
      num_beats = NB_W'($urandom);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      bound = (exp_n + 2) * wave_period + 40;
      seen = 1'b0;
      got_cnt = '0;
      got_ovf = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (restart_at != 0 && i == restart_at) begin
            start = 1'b1;
            num_beats = NB_W'(1);
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            got_cnt = count;
            got_ovf = ovf;
         end
      end
      start = 1'b0;
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s done_timeout: no DONE within %0d cycles", name, bound);
      end else begin
         total++;
         if (got_cnt !== CNT_W'(exp_cnt)) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", name, got_cnt, exp_cnt);
         end
         total++;
         if (got_ovf !== exp_ovf) begin
            bad++;
            $display("FAIL %s ovf: got %b want %b", name, got_ovf, exp_ovf);
         end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, done, busy);
      end
      extra = 0;
      repeat (2 * wave_period) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL %s extra_done: got %0d want 0", name, extra);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      num_beats = NB_W'(3);
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got busy=%b done=%b count=%0d ovf=%b want 0/0/0/0",
                  busy, done, count, ovf);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_with_reset: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_basic();
      set_wave(20, 1'b0);
      run_meas(4, "basic", 0);
   endtask

   task automatic test_zero_beats();
      set_wave(20, 1'b0);
      run_meas(0, "zero_beats", 0);
   endtask

   task automatic test_glitch();
      set_wave(20, 1'b1);
      run_meas(3, "glitch", 0);
      glitch_en = 1'b0;
   endtask

   task automatic test_overflow();
      set_wave(100, 1'b0);
      run_meas(4, "overflow", 0);
      set_wave(20, 1'b0);
      run_meas(2, "after_overflow", 0);
   endtask

   task automatic test_busy_protect();
      set_wave(20, 1'b0);
      run_meas(4, "busy_protect", 40);
   endtask

   task automatic test_reset_mid();
      int dones;
      set_wave(20, 1'b0);
      start = 1'b1;
      num_beats = NB_W'(4);
      @(negedge clk);
      start = 1'b0;
      repeat (45) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || count !== '0 || ovf !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b count=%0d ovf=%b done=%b want 0/0/0/0",
                  busy, count, ovf, done);
      end
      dones = 0;
      repeat (120) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL reset_mid_no_done: got %0d pulses want 0", dones);
      end
      run_meas(4, "after_reset_mid", 0);
   endtask

   task automatic test_back_to_back();
      bit seen;
      set_wave(20, 1'b0);
      start = 1'b1;
      num_beats = NB_W'(1);
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL b2b_first_done: no DONE within 100 cycles");
      end
      start = 1'b1;
      num_beats = NB_W'(2);
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_start_in_fin: got busy=%b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_start_after_fin: got busy=%b want 1", busy);
      end
      seen = 1'b0;
      for (int i = 0; i < 120 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen || count !== CNT_W'(40)) begin
         bad++;
         $display("FAIL b2b_second_count: got seen=%b count=%0d want 1/40", seen, count);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_no_beat();
      int dones;
      wave_on = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      num_beats = NB_W'(2);
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      repeat (400) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      total++;
      if (busy !== 1'b1 || dones != 0) begin
         bad++;
         $display("FAIL no_beat_hang: got busy=%b dones=%0d want 1/0", busy, dones);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL no_beat_recover: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_random();
      int p, n;
      for (int k = 0; k < 8; k++) begin
         p = $urandom_range(8, 40);
         n = $urandom_range(0, 9);
         set_wave(p, 1'($urandom_range(0, 1)));
         run_meas(n, "random", 0);
      end
      glitch_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_beats();
      test_glitch();
      test_overflow();
      test_busy_protect();
      test_reset_mid();
      test_back_to_back();
      test_no_beat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
